// File: rtl/uart_prog_loader_if.sv
// Instruction-memory write port driven by the UART program loader.
interface uart_prog_loader_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 16
);
   logic                  prog_we;
   logic [ADDR_WIDTH-1:0] prog_addr;
   logic [DATA_WIDTH-1:0] prog_wdata;

   modport master (output prog_we, prog_addr, prog_wdata);
   modport slave  (input  prog_we, prog_addr, prog_wdata);
endinterface

// File: rtl/uart_prog_loader.sv
// Serial boot loader: receives a framed image over UART and writes it into
// instruction memory while holding the CPU.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for SYNC_BYTE, CPU free
// LEN_HI  | expecting high byte of word count
// LEN_LO  | expecting low byte of word count, range check
// DATA_HI | expecting high byte of next word
// DATA_LO | expecting low byte, write issued the following cycle
// CHECK   | expecting XOR checksum byte
// DONE    | image loaded, behaves as IDLE
// ERROR   | image invalid, CPU stays held, err_code latched
module uart_prog_loader #(
   parameter int         CLK_FREQ       = 50000000,
   parameter int         BAUD           = 115200,
   parameter int         DATA_WIDTH     = 16,
   parameter int         ADDR_WIDTH     = 12,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 5000000
) (
   input  logic                CLK_50,
   input  logic                resetN,
   input  logic                uart_rx,
   uart_prog_loader_if.master  prog,
   output logic                cpu_hold,
   output logic                loaded,
   output logic                busy,
   output logic [1:0]          err_code
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int TW = $clog2(CLKS_PER_BIT + 1);
   localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] BIT_M1  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [OW-1:0] TO_LOAD = OW'(TIMEOUT_CYCLES);
   localparam logic [16:0]   MAX_LEN = 17'(2 ** ADDR_WIDTH);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
   } state_t;

   rx_state_t       rx_state;
   logic            rx_s1, rx_s2, rx_d;
   logic [TW-1:0]   bit_tmr;
   logic [2:0]      bit_idx;
   logic [7:0]      rx_shift;
   logic            stop_seen, stop_bit;
   logic            byte_valid, frame_err;

   state_t          state;
   logic [7:0]      len_hi, data_hi, chk;
   logic [15:0]     words_left;
   logic [OW-1:0]   to_cnt;
   logic            active;

   // Receiver: sample mid-bit, byte/framing strobes one cycle after the stop sample.
   always_ff @(posedge CLK_50) begin
      if (!resetN) begin
         rx_s1     <= 1'b1;
         rx_s2     <= 1'b1;
         rx_d      <= 1'b1;
         rx_state  <= RX_IDLE;
         bit_tmr   <= '0;
         bit_idx   <= '0;
         rx_shift  <= '0;
         stop_seen <= 1'b0;
         stop_bit  <= 1'b0;
      end else begin
         rx_s1     <= uart_rx;
         rx_s2     <= rx_s1;
         rx_d      <= rx_s2;
         stop_seen <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_d && !rx_s2) begin
                  bit_tmr  <= HALF_M1;
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (bit_tmr == '0) begin
                  if (rx_s2) begin
                     rx_state <= RX_IDLE;
                  end else begin
                     bit_tmr  <= BIT_M1;
                     bit_idx  <= '0;
                     rx_state <= RX_DATA;
                  end
               end else begin
                  bit_tmr <= bit_tmr - 1'b1;
               end
            end
            RX_DATA: begin
               if (bit_tmr == '0) begin
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  bit_tmr  <= BIT_M1;
                  if (bit_idx == 3'd7) rx_state <= RX_STOP;
                  else                 bit_idx  <= bit_idx + 1'b1;
               end else begin
                  bit_tmr <= bit_tmr - 1'b1;
               end
            end
            RX_STOP: begin
               if (bit_tmr == '0) begin
                  stop_seen <= 1'b1;
                  stop_bit  <= rx_s2;
                  rx_state  <= RX_IDLE;
               end else begin
                  bit_tmr <= bit_tmr - 1'b1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   assign byte_valid = stop_seen & stop_bit;
   assign frame_err  = stop_seen & ~stop_bit;
   assign active     = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA_HI) ||
                       (state == S_DATA_LO) || (state == S_CHECK);

   always_ff @(posedge CLK_50) begin
      if (!resetN) begin
         state           <= S_IDLE;
         len_hi          <= '0;
         data_hi         <= '0;
         chk             <= '0;
         words_left      <= '0;
         to_cnt          <= '0;
         prog.prog_we    <= 1'b0;
         prog.prog_addr  <= '0;
         prog.prog_wdata <= '0;
         cpu_hold        <= 1'b0;
         loaded          <= 1'b0;
         busy            <= 1'b0;
         err_code        <= 2'd0;
      end else begin
         prog.prog_we <= 1'b0;
         loaded       <= 1'b0;
         // Advance only when another word follows, so the last address is kept.
         if (prog.prog_we && state == S_DATA_HI) prog.prog_addr <= prog.prog_addr + 1'b1;
         if (active) begin
            if (byte_valid)          to_cnt <= TO_LOAD;
            else if (to_cnt != '0)   to_cnt <= to_cnt - 1'b1;
         end
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (byte_valid && rx_shift == SYNC_BYTE) begin
                  state          <= S_LEN_HI;
                  busy           <= 1'b1;
                  cpu_hold       <= 1'b1;
                  err_code       <= 2'd0;
                  prog.prog_addr <= '0;
                  chk            <= '0;
                  to_cnt         <= TO_LOAD;
               end
            end
            default: begin
               if (frame_err || (!byte_valid && to_cnt == '0)) begin
                  state    <= S_ERROR;
                  err_code <= 2'd2;
                  busy     <= 1'b0;
               end else if (byte_valid) begin
                  chk <= chk ^ rx_shift;
                  case (state)
                     S_LEN_HI: begin
                        len_hi <= rx_shift;
                        state  <= S_LEN_LO;
                     end
                     S_LEN_LO: begin
                        if ({1'b0, len_hi, rx_shift} > MAX_LEN) begin
                           state    <= S_ERROR;
                           err_code <= 2'd3;
                           busy     <= 1'b0;
                        end else if ({len_hi, rx_shift} == 16'd0) begin
                           state <= S_CHECK;
                        end else begin
                           words_left <= {len_hi, rx_shift};
                           state      <= S_DATA_HI;
                        end
                     end
                     S_DATA_HI: begin
                        data_hi <= rx_shift;
                        state   <= S_DATA_LO;
                     end
                     S_DATA_LO: begin
                        prog.prog_we    <= 1'b1;
                        prog.prog_wdata <= {data_hi, rx_shift};
                        words_left      <= words_left - 1'b1;
                        state           <= (words_left == 16'd1) ? S_CHECK : S_DATA_HI;
                     end
                     S_CHECK: begin
                        busy <= 1'b0;
                        if (chk == rx_shift) begin
                           state    <= S_DONE;
                           loaded   <= 1'b1;
                           cpu_hold <= 1'b0;
                        end else begin
                           state    <= S_ERROR;
                           err_code <= 2'd1;
                        end
                     end
                     default: state <= S_IDLE;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader with a short bit period and timeout.
module tb_uart_prog_loader;
   localparam int CPB = 16;
   localparam int TO  = 400;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       uart_rx = 1'b1;
   logic       cpu_hold, loaded, busy;
   logic [1:0] err_code;

   uart_prog_loader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) pif ();

   uart_prog_loader #(
      .CLK_FREQ(1600), .BAUD(100), .DATA_WIDTH(16), .ADDR_WIDTH(12),
      .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)
   ) dut (
      .CLK_50(clk), .resetN(resetN), .uart_rx(uart_rx), .prog(pif),
      .cpu_hold(cpu_hold), .loaded(loaded), .busy(busy), .err_code(err_code)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_err = 0;
   int          load_cnt = 0;
   int          l0;
   logic [27:0] exp_q[$];
   logic [7:0]  pkt[$];

   task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops expected writes whenever the DUT strobes prog_we.
   initial begin
      logic [27:0] e;
      forever begin
         @(negedge clk);
         if (loaded) load_cnt++;
         if (pif.prog_we) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_write: addr %0h data %0h", pif.prog_addr, pif.prog_wdata);
            end else begin
               e = exp_q.pop_front();
               check("write", {pif.prog_addr, pif.prog_wdata}, e);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stop;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_pkt();
      foreach (pkt[i]) send_byte(pkt[i], 1'b1);
      repeat (20) @(negedge clk);
   endtask

   task automatic outputs_zero(input string name);
      check(name, {pif.prog_we, pif.prog_addr, pif.prog_wdata, cpu_hold, loaded, busy, err_code}, 40'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      outputs_zero("in_reset");
      resetN = 1'b1;
      @(negedge clk);
      outputs_zero("after_reset");
      repeat (1000) @(negedge clk);
      check("idle_cpu_hold", cpu_hold, 0);

      // valid two-word image
      exp_q.push_back({12'h000, 16'h1234});
      exp_q.push_back({12'h001, 16'hABCD});
      l0 = load_cnt;
      send_byte(8'hA5, 1'b1);
      check("sync_busy", busy, 1);
      check("sync_hold", cpu_hold, 1);
      pkt = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
      send_pkt();
      check("ok_writes_done", exp_q.size(), 0);
      check("ok_loaded", load_cnt - l0, 1);
      check("ok_hold", cpu_hold, 0);
      check("ok_busy", busy, 0);
      check("ok_err", err_code, 0);

      // bad checksum, then recovery
      exp_q.push_back({12'h000, 16'h1234});
      exp_q.push_back({12'h001, 16'hABCD});
      l0 = load_cnt;
      pkt = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
      send_pkt();
      check("badchk_writes", exp_q.size(), 0);
      check("badchk_err", err_code, 1);
      check("badchk_hold", cpu_hold, 1);
      check("badchk_busy", busy, 0);
      check("badchk_noload", load_cnt - l0, 0);
      exp_q.push_back({12'h000, 16'h1234});
      exp_q.push_back({12'h001, 16'hABCD});
      l0 = load_cnt;
      pkt = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
      send_pkt();
      check("retry_loaded", load_cnt - l0, 1);
      check("retry_err", err_code, 0);
      check("retry_hold", cpu_hold, 0);

      // length 4097 rejected, length 0 accepted
      pkt = '{8'hA5, 8'h10, 8'h01};
      send_pkt();
      check("len_err", err_code, 3);
      check("len_hold", cpu_hold, 1);
      check("len_busy", busy, 0);
      l0 = load_cnt;
      pkt = '{8'hA5, 8'h00, 8'h00, 8'h00};
      send_pkt();
      check("zero_loaded", load_cnt - l0, 1);
      check("zero_err", err_code, 0);

      // inter-byte timeout inside a word
      pkt = '{8'hA5, 8'h00, 8'h01, 8'h12};
      send_pkt();
      check("pre_timeout_err", err_code, 0);
      repeat (TO + 50) @(negedge clk);
      check("timeout_err", err_code, 2);
      check("timeout_hold", cpu_hold, 1);
      check("timeout_busy", busy, 0);

      // framing error on LEN_HI
      send_byte(8'hA5, 1'b1);
      check("restart_err_clear", err_code, 0);
      send_byte(8'h00, 1'b0);
      repeat (20) @(negedge clk);
      check("frame_err", err_code, 2);
      check("frame_busy", busy, 0);

      // reset while in DATA_HI
      pkt = '{8'hA5, 8'h00, 8'h02};
      send_pkt();
      check("mid_busy", busy, 1);
      resetN = 1'b0;
      @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
      outputs_zero("mid_reset");
      l0 = load_cnt;
      pkt = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
      send_pkt();
      check("post_reset_idle", load_cnt - l0, 0);
      check("post_reset_busy", busy, 0);

      // short glitch in IDLE must not be taken as a start bit
      uart_rx = 1'b0;
      repeat (6) @(negedge clk);
      uart_rx = 1'b1;
      repeat (4) @(negedge clk);
      l0 = load_cnt;
      pkt = '{8'hA5, 8'h00, 8'h00, 8'h00};
      send_pkt();
      check("glitch_ignored", load_cnt - l0, 1);

      check("final_queue", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
